// File: rtl/adc_snap_capture_ctrl_pkg.sv
// Shared types and constants for the ADC snapshot capture path and the snapshot RAM wrapper.
package adc_snap_capture_ctrl_pkg;

  localparam int SNAP_DATA_WIDTH = 64;
  localparam int SNAP_ADDR_WIDTH = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } snap_state_e;

endpackage

// File: rtl/adc_snap_capture_ctrl.sv
// Write-side controller for the ADC calibration snapshot: arms, triggers, then fills
// the snapshot RAM port A exactly once with consecutive valid samples.
module adc_snap_capture_ctrl
  import adc_snap_capture_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = SNAP_DATA_WIDTH,
  parameter int ADDR_WIDTH = SNAP_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  trig,
  input  logic                  ctrl_arm,
  input  logic                  ctrl_trig_src,
  output logic                  bram_we,
  output logic                  bram_en_a,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wr_data,
  output logic                  status_done,
  output logic [ADDR_WIDTH:0]   status_count,
  output logic                  status_armed
);

  localparam logic [ADDR_WIDTH:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] ONE      = 1;

  snap_state_e           state, state_next;
  logic                  ctrl_arm_q;
  logic                  arm_edge;
  logic                  trig_hit;
  logic                  accept;
  logic                  count_clear;
  logic                  we_q;
  logic [ADDR_WIDTH:0]   count;

  assign arm_edge = ctrl_arm & ~ctrl_arm_q;
  assign trig_hit = ctrl_trig_src ? trig : 1'b1;

  // The trigger-cycle sample is taken in ARMED itself so it lands at word 0.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    count_clear = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (arm_edge) begin
          state_next  = ARMED;
          count_clear = 1'b1;
        end
      end
      ARMED: begin
        if (trig_hit) begin
          accept     = din_valid;
          state_next = (din_valid && (count == LAST_IDX)) ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (din_valid) begin
          accept = 1'b1;
          if (count == LAST_IDX) begin
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ctrl_arm_q   <= 1'b0;
      count        <= '0;
      we_q         <= 1'b0;
      bram_addr    <= '0;
      bram_wr_data <= '0;
    end else begin
      state      <= state_next;
      ctrl_arm_q <= ctrl_arm;
      we_q       <= accept;
      if (count_clear) begin
        count <= '0;
      end else if (accept) begin
        count <= count + ONE;
      end
      if (accept) begin
        bram_addr    <= count[ADDR_WIDTH-1:0];
        bram_wr_data <= din;
      end
    end
  end

  // Gating with rst keeps a write registered just before reset from reaching the RAM.
  assign bram_we      = we_q & ~rst;
  assign bram_en_a    = ~rst;
  assign status_done  = (state == DONE);
  assign status_armed = (state == ARMED) || (state == CAPTURE);
  assign status_count = count;

endmodule

// File: tb/tb_adc_snap_capture_ctrl.sv
// Randomized self-checking bench for adc_snap_capture_ctrl against a behavioural
// model of the arm / trigger / capture rules.
module tb_adc_snap_capture_ctrl;

  localparam int DW    = 64;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          trig;
  logic          ctrl_arm;
  logic          ctrl_trig_src;
  logic          bram_we;
  logic          bram_en_a;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wr_data;
  logic          status_done;
  logic [AW:0]   status_count;
  logic          status_armed;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: capture flags, words written, and the expected output picture.
  logic          m_arm_prev = 1'b0;
  bit            m_armed    = 1'b0;
  bit            m_capt     = 1'b0;
  bit            m_done     = 1'b0;
  int            m_words    = 0;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic [AW+4:0] exp_status;

  logic [AW+4:0]  obs_status;
  logic [AW+DW-1:0] obs_wr;
  assign obs_status = {bram_en_a, bram_we, status_done, status_armed, status_count};
  assign obs_wr     = {bram_addr, bram_wr_data};

  always #5 clk = ~clk;

  adc_snap_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_valid    (din_valid),
    .trig         (trig),
    .ctrl_arm     (ctrl_arm),
    .ctrl_trig_src(ctrl_trig_src),
    .bram_we      (bram_we),
    .bram_en_a    (bram_en_a),
    .bram_addr    (bram_addr),
    .bram_wr_data (bram_wr_data),
    .status_done  (status_done),
    .status_count (status_count),
    .status_armed (status_armed)
  );

  function automatic logic [DW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic model_step(input logic r, a, src, t, v, input logic [DW-1:0] d);
    bit take;
    take   = 1'b0;
    exp_we = 1'b0;
    if (r) begin
      m_arm_prev = 1'b0;
      m_armed    = 1'b0;
      m_capt     = 1'b0;
      m_done     = 1'b0;
      m_words    = 0;
      exp_addr   = '0;
      exp_data   = '0;
    end else begin
      if (a && !m_arm_prev && !m_armed && !m_capt) begin
        m_armed = 1'b1;
        m_done  = 1'b0;
        m_words = 0;
      end else if (m_armed && (t || !src)) begin
        m_armed = 1'b0;
        m_capt  = 1'b1;
        take    = 1'b1;
      end else if (m_capt) begin
        take = 1'b1;
      end
      m_arm_prev = a;
      if (take && v) begin
        exp_we   = 1'b1;
        exp_addr = AW'(m_words % DEPTH);
        exp_data = d;
        m_words++;
        if (m_words == DEPTH) begin
          m_capt = 1'b0;
          m_done = 1'b1;
        end
      end
    end
    exp_status = {~r, exp_we, m_done, m_armed | m_capt, (AW+1)'(m_words)};
  endtask

  // Present one cycle of inputs, advance the model at the edge, settle before returning.
  task automatic drive(input logic r, a, src, t, v, input logic [DW-1:0] d);
    rst = r; ctrl_arm = a; ctrl_trig_src = src; trig = t; din_valid = v; din = d;
    @(posedge clk);
    model_step(r, a, src, t, v, d);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rnd64());
      checks++;
      if (obs_status !== '0) begin
        errors++; $display("[TB] FAIL reset_status cyc=%0d got=%h exp=0", cyc, obs_status);
      end
      checks++;
      if (obs_wr !== '0) begin
        errors++; $display("[TB] FAIL reset_wr cyc=%0d got=%h exp=0", cyc, obs_wr);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rnd64());
    checks++;
    if (obs_status !== {1'b1, 1'b0, 1'b0, 1'b0, 10'd0}) begin
      errors++; $display("[TB] FAIL post_reset_idle got=%h exp=%h", obs_status, {1'b1, 13'd0});
    end
  endtask

  task automatic test_immediate();
    logic [DW-1:0] v;
    int n_wr, guard;
    v = 64'h100; n_wr = 0; guard = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rnd64());
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, rnd64());
    checks++;
    if (status_armed !== 1'b1 || bram_we !== 1'b0) begin
      errors++; $display("[TB] FAIL imm_arm armed=%b we=%b exp armed=1 we=0", status_armed, bram_we);
    end
    while (status_done !== 1'b1 && guard < 600) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, v);
      v++; guard++;
      checks++;
      if (obs_status !== exp_status) begin
        errors++; $display("[TB] FAIL imm_status cyc=%0d got=%h exp=%h", cyc, obs_status, exp_status);
      end
      if (bram_we === 1'b1) begin
        checks++;
        if (bram_addr !== AW'(n_wr) || bram_wr_data !== 64'h100 + 64'(n_wr)) begin
          errors++; $display("[TB] FAIL imm_word n=%0d got=%h/%h exp=%h/%h", n_wr, bram_addr,
                             bram_wr_data, AW'(n_wr), 64'h100 + 64'(n_wr));
        end
        n_wr++;
      end
    end
    checks++;
    if (n_wr != DEPTH || status_count !== 10'd512 || bram_we !== 1'b1 || bram_addr !== 9'd511) begin
      errors++; $display("[TB] FAIL imm_final writes=%0d count=%0d we=%b addr=%0d exp 512/512/1/511",
                         n_wr, status_count, bram_we, bram_addr);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, v);
    checks++;
    if (bram_we !== 1'b0 || status_done !== 1'b1) begin
      errors++; $display("[TB] FAIL imm_after_done we=%b done=%b exp we=0 done=1", bram_we, status_done);
    end
  endtask

  task automatic test_ext_trigger();
    logic [DW-1:0] tdata;
    int guard;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, rnd64());
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, rnd64());
    for (int i = 0; i < 50; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), rnd64());
      checks++;
      if (bram_we !== 1'b0 || obs_status !== exp_status) begin
        errors++; $display("[TB] FAIL ext_wait cyc=%0d got=%h exp=%h", cyc, obs_status, exp_status);
      end
    end
    tdata = rnd64();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, tdata);
    checks++;
    if (bram_we !== 1'b1 || bram_addr !== 9'd0 || bram_wr_data !== tdata) begin
      errors++; $display("[TB] FAIL ext_word0 got=%b/%h/%h exp=1/0/%h", bram_we, bram_addr, bram_wr_data, tdata);
    end
    guard = 0;
    while (status_done !== 1'b1 && guard < 2000) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), rnd64());
      guard++;
      checks++;
      if (obs_status !== exp_status) begin
        errors++; $display("[TB] FAIL ext_status cyc=%0d got=%h exp=%h", cyc, obs_status, exp_status);
      end
      checks++;
      if (obs_wr !== {exp_addr, exp_data}) begin
        errors++; $display("[TB] FAIL ext_wr cyc=%0d got=%h exp=%h", cyc, obs_wr, {exp_addr, exp_data});
      end
    end
    checks++;
    if (status_done !== 1'b1 || status_count !== 10'd512) begin
      errors++; $display("[TB] FAIL ext_final done=%b count=%0d exp 1/512", status_done, status_count);
    end
  endtask

  // Trigger held high across the arm edge; valid alternates so completion takes ~1024 cycles.
  task automatic test_toggle_valid();
    int guard, n_wr;
    guard = 0; n_wr = 0;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, rnd64());
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, rnd64());
    while (status_done !== 1'b1 && guard < 1100) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'(guard % 2 == 0), rnd64());
      guard++;
      checks++;
      if (obs_status !== exp_status || obs_wr !== {exp_addr, exp_data}) begin
        errors++; $display("[TB] FAIL tog_cycle cyc=%0d got=%h/%h exp=%h/%h", cyc, obs_status,
                           obs_wr, exp_status, {exp_addr, exp_data});
      end
      if (bram_we === 1'b1) begin
        checks++;
        if (bram_addr !== AW'(n_wr)) begin
          errors++; $display("[TB] FAIL tog_addr got=%0d exp=%0d", bram_addr, n_wr);
        end
        n_wr++;
      end
    end
    checks++;
    if (guard != 1023 || n_wr != DEPTH) begin
      errors++; $display("[TB] FAIL tog_length cycles=%0d writes=%0d exp 1023/512", guard, n_wr);
    end
  endtask

  task automatic test_rearm();
    int guard;
    guard = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rnd64());
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, rnd64());
    checks++;
    if (status_done !== 1'b0 || status_count !== 10'd0 || status_armed !== 1'b1) begin
      errors++; $display("[TB] FAIL rearm_clear done=%b count=%0d armed=%b exp 0/0/1",
                         status_done, status_count, status_armed);
    end
    while (status_done !== 1'b1 && guard < 600) begin
      drive(1'b0, 1'(!(guard >= 100 && guard < 103)), 1'b0, 1'b0, 1'b1, rnd64());
      guard++;
      checks++;
      if (obs_status !== exp_status || obs_wr !== {exp_addr, exp_data}) begin
        errors++; $display("[TB] FAIL rearm_cycle cyc=%0d got=%h/%h exp=%h/%h", cyc, obs_status,
                           obs_wr, exp_status, {exp_addr, exp_data});
      end
    end
    checks++;
    if (guard != DEPTH || status_count !== 10'd512) begin
      errors++; $display("[TB] FAIL rearm_length cycles=%0d count=%0d exp 512/512", guard, status_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d0;
    int guard;
    guard = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rnd64());
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, rnd64());
    while (status_count !== 10'd200 && guard < 300) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, rnd64());
      guard++;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rnd64());
    checks++;
    if (obs_status !== '0 || obs_wr !== '0) begin
      errors++; $display("[TB] FAIL rstmid_zero got=%h/%h exp=0/0", obs_status, obs_wr);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rnd64());
      checks++;
      if (obs_status !== {1'b1, 13'd0}) begin
        errors++; $display("[TB] FAIL rstmid_idle cyc=%0d got=%h exp=%h", cyc, obs_status, {1'b1, 13'd0});
      end
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, rnd64());
    d0 = rnd64();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, d0);
    checks++;
    if (bram_we !== 1'b1 || bram_addr !== 9'd0 || bram_wr_data !== d0 || status_count !== 10'd1) begin
      errors++; $display("[TB] FAIL rstmid_fresh got=%b/%0d/%h/%0d exp=1/0/%h/1",
                         bram_we, bram_addr, bram_wr_data, status_count, d0);
    end
  endtask

  // Continues the capture started above with arm held, then keeps arm high after done.
  task automatic test_arm_held();
    int guard;
    guard = 0;
    while (status_done !== 1'b1 && guard < 1200) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), rnd64());
      guard++;
      checks++;
      if (obs_status !== exp_status || obs_wr !== {exp_addr, exp_data}) begin
        errors++; $display("[TB] FAIL held_cycle cyc=%0d got=%h/%h exp=%h/%h", cyc, obs_status,
                           obs_wr, exp_status, {exp_addr, exp_data});
      end
    end
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd64());
      checks++;
      if (obs_status !== {1'b1, 1'b0, 1'b1, 1'b0, 10'd512}) begin
        errors++; $display("[TB] FAIL held_no_rearm cyc=%0d got=%h exp=%h", cyc, obs_status,
                           {1'b1, 1'b0, 1'b1, 1'b0, 10'd512});
      end
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_ext_trigger();
    test_toggle_valid();
    test_rearm();
    test_reset_mid();
    test_arm_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_snap_capture_ctrl.md
# adc_snap_capture_ctrl

Write-side controller for the ADC-input calibration snapshot. It accepts a stream of 64-bit ADC sample words and waits for a software arm and a trigger. It then fills the 512 × 64 snapshot RAM's port A exactly once with consecutive valid samples and reports completion to software. It sits directly upstream of the snapshot BRAM block and drives its `bram_we`, `bram_en_a`, `bram_addr` and `bram_wr_data` inputs. Software reads the captured data back through port B.

## Interface
Parameters:
- `DATA_WIDTH`, 64: sample word width; must equal the RAM port A width.
- `ADDR_WIDTH`, 9: RAM port A address width; capture length is 2^ADDR_WIDTH words.

Ports:
- `clk`, in, 1: the single clock, shared by the RAM port A.
- `rst`, in, 1: reset; synchronous, active-high.
- `din`, in, DATA_WIDTH: ADC sample word.
- `din_valid`, in, 1: `din` is valid this cycle.
- `trig`, in, 1: external trigger, level-sampled each cycle.
- `ctrl_arm`, in, 1: software arm bit; only its 0→1 edge acts.
- `ctrl_trig_src`, in, 1: trigger select; 1 = wait for `trig`, 0 = trigger immediately once armed.
- `bram_we`, out, 1: RAM port A write enable.
- `bram_en_a`, out, 1: RAM port A enable.
- `bram_addr`, out, ADDR_WIDTH: RAM port A address.
- `bram_wr_data`, out, DATA_WIDTH: RAM port A write data.
- `status_done`, out, 1: capture complete.
- `status_count`, out, ADDR_WIDTH+1: number of words written in the current or last capture (0..512).
- `status_armed`, out, 1: state is ARMED or CAPTURE.

## Operation
- State machine with four states: IDLE, ARMED, CAPTURE, DONE.
- Arm edge: `arm_edge = ctrl_arm & ~ctrl_arm_q`, where `ctrl_arm_q` is `ctrl_arm` registered; `ctrl_arm_q` resets to 0.
- IDLE:
  - On `arm_edge`: go to ARMED, clear `status_done`, clear the write counter to 0.
- ARMED:
  - Trigger condition: `trig_hit = ctrl_trig_src ? trig : 1`.
  - On `trig_hit`: go to CAPTURE.
  - The sample presented in the trigger cycle is captured if `din_valid` is high, so the trigger-cycle sample becomes word 0.
- CAPTURE:
  - Each cycle with `din_valid` high issues one write at the current counter value, then increments the counter.
  - Cycles with `din_valid` low issue no write and leave the counter unchanged.
  - After the write at counter value 2^ADDR_WIDTH−1 is issued: go to DONE.
- DONE:
  - `status_done` = 1.
  - No further writes.
  - On `arm_edge`: behave as in IDLE (go to ARMED, clear done and counter).
- `arm_edge` in ARMED or CAPTURE is ignored; a capture cannot be restarted.
- `trig` is ignored outside ARMED.
- `trig` held high across the arm edge fires on the first ARMED cycle.
- The counter is ADDR_WIDTH+1 bits.
  - `bram_addr` is the counter's low ADDR_WIDTH bits, taken at write-issue time.
  - The counter never wraps: it saturates at 2^ADDR_WIDTH on completion.
  - `status_count` is the counter value.
- `bram_en_a` is 1 whenever `rst` is low.
- All outputs reset to 0 and the state resets to IDLE. Reset asserted mid-capture abandons the capture, and no write occurs in the reset cycle or after it.

## Timing
- Write path has one register stage. A sample accepted in cycle N appears as `bram_we`=1 with its `bram_addr` and `bram_wr_data` in cycle N+1.
- `bram_we` is high for exactly one cycle per accepted sample. `bram_addr` and `bram_wr_data` hold their last values when `bram_we` is low.
- Arm edge in cycle N:
  - `status_armed` is high from N+1.
  - Earliest accepted sample is in cycle N+1 (immediate trigger source).
- `status_done` rises in the same cycle as the final `bram_we` (address 511), so software sees done no earlier than the last write.
- Back-to-back valid input gives 512 consecutive write cycles.
- Throughput is one word per clock, with no backpressure: `din_valid` is never stalled.

## Structure
- Shared package holds:
  - the state enum (IDLE/ARMED/CAPTURE/DONE);
  - `SNAP_DATA_WIDTH` = 64 and `SNAP_ADDR_WIDTH` = 9, the shared constants between this block and the RAM wrapper.
- No sub-module needed. An optional `edge_detect_rise` helper may be used for the arm edge.

## Test plan
- Immediate trigger, continuous valid, `din` = incrementing count from 0x100:
  - -> 512 writes to addresses 0..511 with data 0x100..0x2FF;
  - `status_done`=1 with the final write;
  - `status_count`=512.
- External trigger: arm, hold `trig`=0 for 50 cycles, then pulse `trig` for 1 cycle:
  - -> no writes before the pulse;
  - word 0 = sample in the trigger cycle.
- `din_valid` toggling 1,0,1,0:
  - -> only valid samples written, addresses still contiguous;
  - completion after 512 valid samples (about 1024 cycles).
- Re-arm: `ctrl_arm` toggled in mid-capture is ignored; arm again after DONE:
  - -> done clears, counter returns to 0, second full capture.
- Reset asserted at word 200 of a capture:
  - -> all outputs 0 the next cycle, no further `bram_we`, state IDLE;
  - a new arm edge starts a fresh capture at address 0.
- `ctrl_arm` held high continuously after DONE:
  - -> no re-arm without a fresh 0→1 edge.
